// File: rtl/pmem_arbiter_fsm.sv
// Two-requester arbiter for the single physical-memory port: D-cache has priority,
// with a starvation streak that forces an I-cache grant after STARVE_LIMIT D grants.
module pmem_arbiter_fsm #(
   parameter int ADDR_W       = 16,
   parameter int BLOCK_W      = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               icache_pmem_read,
   input  logic [ADDR_W-1:0]  icache_pmem_address,
   input  logic               dcache_pmem_read,
   input  logic               dcache_pmem_write,
   input  logic [ADDR_W-1:0]  dcache_pmem_address,
   input  logic [BLOCK_W-1:0] dcache_pmem_wdata,
   input  logic               pmem_resp,
   input  logic [BLOCK_W-1:0] pmem_rdata,
   output logic               icache_mem_resp,
   output logic [BLOCK_W-1:0] icache_mem_rdata,
   output logic               dcache_mem_resp,
   output logic [BLOCK_W-1:0] dcache_mem_rdata,
   output logic               pmem_read,
   output logic               pmem_write,
   output logic [ADDR_W-1:0]  pmem_address,
   output logic [BLOCK_W-1:0] pmem_wdata,
   output logic               arb_busy
);

   localparam int STRK_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_I_BUSY = 2'd1,
      ST_D_BUSY = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   logic [STRK_W-1:0]  r_streak;
   logic               r_pmem_read;
   logic               r_pmem_write;
   logic [ADDR_W-1:0]  r_pmem_address;
   logic [BLOCK_W-1:0] r_pmem_wdata;

   logic w_d_req;
   logic w_starved;
   logic w_grant_i;

   assign w_d_req   = dcache_pmem_read | dcache_pmem_write;
   assign w_starved = (r_streak == STRK_W'(STARVE_LIMIT));
   assign w_grant_i = icache_pmem_read & (~w_d_req | w_starved);

   // Arbitration FSM; strobes, address, write data and the streak are all registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_streak       <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_pmem_address <= '0;
         r_pmem_wdata   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_i) begin
                  r_state        <= ST_I_BUSY;
                  r_pmem_read    <= 1'b1;
                  r_pmem_write   <= 1'b0;
                  r_pmem_address <= icache_pmem_address;
                  r_streak       <= '0;
               end else if (w_d_req) begin
                  // A simultaneous read+write is illegal; the write-back takes precedence.
                  r_state        <= ST_D_BUSY;
                  r_pmem_write   <= dcache_pmem_write;
                  r_pmem_read    <= ~dcache_pmem_write;
                  r_pmem_address <= dcache_pmem_address;
                  if (dcache_pmem_write) begin
                     r_pmem_wdata <= dcache_pmem_wdata;
                  end
                  if (icache_pmem_read && !w_starved) begin
                     r_streak <= r_streak + STRK_W'(1);
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_I_BUSY, ST_D_BUSY: begin
               if (pmem_resp) begin
                  r_state      <= ST_DONE;
                  r_pmem_read  <= 1'b0;
                  r_pmem_write <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_pmem_read  <= 1'b0;
               r_pmem_write <= 1'b0;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_pmem_read  <= 1'b0;
               r_pmem_write <= 1'b0;
            end
         endcase
      end
   end

   assign pmem_read        = r_pmem_read;
   assign pmem_write       = r_pmem_write;
   assign pmem_address     = r_pmem_address;
   assign pmem_wdata       = r_pmem_wdata;
   assign arb_busy         = (r_state == ST_I_BUSY) | (r_state == ST_D_BUSY);
   // Completion is forwarded in the same cycle as pmem_resp, only to the current owner.
   assign icache_mem_resp  = (r_state == ST_I_BUSY) & pmem_resp;
   assign dcache_mem_resp  = (r_state == ST_D_BUSY) & pmem_resp;
   assign icache_mem_rdata = pmem_rdata;
   assign dcache_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter_fsm.sv
// Self-checking bench for pmem_arbiter_fsm: directed vector table, starvation and
// reset sequences, then random traffic against a transaction-level reference model.
module tb_pmem_arbiter_fsm;

   localparam int ADDR_W  = 16;
   localparam int BLOCK_W = 128;
   localparam int LIMIT   = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               ir, dr, dw, resp;
   logic [ADDR_W-1:0]  ia, da;
   logic [BLOCK_W-1:0] wd, rdat;
   logic               i_resp, d_resp, p_rd, p_wr, busy;
   logic [BLOCK_W-1:0] i_rdata, d_rdata, p_wd;
   logic [ADDR_W-1:0]  p_addr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pmem_arbiter_fsm #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .icache_pmem_read(ir), .icache_pmem_address(ia),
      .dcache_pmem_read(dr), .dcache_pmem_write(dw),
      .dcache_pmem_address(da), .dcache_pmem_wdata(wd),
      .pmem_resp(resp), .pmem_rdata(rdat),
      .icache_mem_resp(i_resp), .icache_mem_rdata(i_rdata),
      .dcache_mem_resp(d_resp), .dcache_mem_rdata(d_rdata),
      .pmem_read(p_rd), .pmem_write(p_wr),
      .pmem_address(p_addr), .pmem_wdata(p_wd), .arb_busy(busy)
   );

   typedef struct packed {
      logic               ir;
      logic [ADDR_W-1:0]  ia;
      logic               dr;
      logic               dw;
      logic [ADDR_W-1:0]  da;
      logic [BLOCK_W-1:0] wd;
      logic               resp;
      logic [BLOCK_W-1:0] rd;
      logic               e_rd;
      logic               e_wr;
      logic [ADDR_W-1:0]  e_addr;
      logic [BLOCK_W-1:0] e_wd;
      logic               e_ir;
      logic               e_dr;
      logic               e_busy;
   } vec_t;

   vec_t vt [18];

   function automatic vec_t mk(logic a_ir, logic [15:0] a_ia, logic a_dr, logic a_dw,
                               logic [15:0] a_da, logic [127:0] a_wd, logic a_resp,
                               logic [127:0] a_rd, logic x_rd, logic x_wr,
                               logic [15:0] x_addr, logic [127:0] x_wd,
                               logic x_ir, logic x_dr, logic x_busy);
      vec_t v;
      v = {a_ir, a_ia, a_dr, a_dw, a_da, a_wd, a_resp, a_rd,
           x_rd, x_wr, x_addr, x_wd, x_ir, x_dr, x_busy};
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string tag, input logic x_rd, input logic x_wr,
                           input logic [15:0] x_addr, input logic [127:0] x_wd,
                           input logic x_ir, input logic x_dr, input logic x_busy);
      chk({tag, ".pmem_read"},  128'(p_rd),   128'(x_rd));
      chk({tag, ".pmem_write"}, 128'(p_wr),   128'(x_wr));
      chk({tag, ".pmem_addr"},  128'(p_addr), 128'(x_addr));
      chk({tag, ".pmem_wdata"}, p_wd,         x_wd);
      chk({tag, ".i_resp"},     128'(i_resp), 128'(x_ir));
      chk({tag, ".d_resp"},     128'(d_resp), 128'(x_dr));
      chk({tag, ".arb_busy"},   128'(busy),   128'(x_busy));
      chk({tag, ".i_rdata"},    i_rdata,      rdat);
      chk({tag, ".d_rdata"},    d_rdata,      rdat);
   endtask

   task automatic drive(input logic a_ir, input logic [15:0] a_ia, input logic a_dr,
                        input logic a_dw, input logic [15:0] a_da, input logic [127:0] a_wd,
                        input logic a_resp, input logic [127:0] a_rd);
      ir = a_ir; ia = a_ia; dr = a_dr; dw = a_dw; da = a_da; wd = a_wd;
      resp = a_resp; rdat = a_rd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 128'h0, 1'b0, 128'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model state: who owns the port, the dead cycle after a transfer, the streak.
   int               m_owner;
   bit               m_cool;
   int               m_streak;
   logic             m_rd, m_wr;
   logic [15:0]      m_addr;
   logic [127:0]     m_wd;

   initial begin
      logic [127:0] w1, w2, ra, rb, rc, rd2, re;
      logic [15:0]  got_addr [$];
      logic [15:0]  exp_addr;
      int           cyc;
      bit           d_req;

      w1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F0E1_D2C3;
      w2 = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1234_8765;
      ra = 128'hA0A0_0000_0000_0000_0000_0000_0000_00A1;
      rb = 128'hB0B0_0000_0000_0000_0000_0000_0000_00B1;
      rc = 128'hC0C0_0000_0000_0000_0000_0000_0000_00C1;
      rd2 = 128'hD0D0_0000_0000_0000_0000_0000_0000_00D1;
      re = 128'hE0E0_0000_0000_0000_0000_0000_0000_00E1;

      //          ir   ia       dr   dw   da       wd    resp  rdata  e_rd e_wr e_addr  e_wd  e_ir e_dr e_busy
      vt[0]  = mk(1'b0,16'h0000,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b0,1'b0,16'h0000,128'h0,1'b0,1'b0,1'b0);
      vt[1]  = mk(1'b1,16'h1230,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b0,1'b0,16'h0000,128'h0,1'b0,1'b0,1'b0);
      vt[2]  = mk(1'b1,16'h1230,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b1,1'b0,16'h1230,128'h0,1'b0,1'b0,1'b1);
      vt[3]  = mk(1'b1,16'h1230,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b1,1'b0,16'h1230,128'h0,1'b0,1'b0,1'b1);
      vt[4]  = mk(1'b1,16'h1230,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b1,1'b0,16'h1230,128'h0,1'b0,1'b0,1'b1);
      vt[5]  = mk(1'b1,16'h1230,1'b0,1'b0,16'h0000,128'h0,1'b1,ra,    1'b1,1'b0,16'h1230,128'h0,1'b1,1'b0,1'b1);
      vt[6]  = mk(1'b0,16'h0000,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b0,1'b0,16'h1230,128'h0,1'b0,1'b0,1'b0);
      vt[7]  = mk(1'b1,16'h2222,1'b0,1'b1,16'h4000,w1,    1'b0,128'h0,1'b0,1'b0,16'h1230,128'h0,1'b0,1'b0,1'b0);
      vt[8]  = mk(1'b1,16'h2222,1'b0,1'b1,16'h4000,w1,    1'b1,rb,    1'b0,1'b1,16'h4000,w1,    1'b0,1'b1,1'b1);
      vt[9]  = mk(1'b1,16'h2222,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b0,1'b0,16'h4000,w1,    1'b0,1'b0,1'b0);
      vt[10] = mk(1'b1,16'h2222,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b0,1'b0,16'h4000,w1,    1'b0,1'b0,1'b0);
      vt[11] = mk(1'b1,16'h2222,1'b0,1'b0,16'h0000,128'h0,1'b1,rc,    1'b1,1'b0,16'h2222,w1,    1'b1,1'b0,1'b1);
      vt[12] = mk(1'b0,16'h0000,1'b0,1'b0,16'h0000,128'h0,1'b1,rd2,   1'b0,1'b0,16'h2222,w1,    1'b0,1'b0,1'b0);
      vt[13] = mk(1'b0,16'h0000,1'b0,1'b0,16'h0000,128'h0,1'b1,rd2,   1'b0,1'b0,16'h2222,w1,    1'b0,1'b0,1'b0);
      vt[14] = mk(1'b0,16'h0000,1'b1,1'b1,16'h5550,w2,    1'b0,128'h0,1'b0,1'b0,16'h2222,w1,    1'b0,1'b0,1'b0);
      vt[15] = mk(1'b0,16'h0000,1'b1,1'b1,16'h7777,w2,    1'b0,128'h0,1'b0,1'b1,16'h5550,w2,    1'b0,1'b0,1'b1);
      vt[16] = mk(1'b0,16'h0000,1'b1,1'b1,16'h7777,w2,    1'b1,re,    1'b0,1'b1,16'h5550,w2,    1'b0,1'b1,1'b1);
      vt[17] = mk(1'b0,16'h0000,1'b0,1'b0,16'h0000,128'h0,1'b0,128'h0,1'b0,1'b0,16'h5550,w2,    1'b0,1'b0,1'b0);

      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 128'h0, 1'b0, 128'h0);
      do_reset();

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dw, vt[i].da, vt[i].wd, vt[i].resp, vt[i].rd);
         #1;
         chk_outs($sformatf("vec%0d", i), vt[i].e_rd, vt[i].e_wr, vt[i].e_addr, vt[i].e_wd,
                  vt[i].e_ir, vt[i].e_dr, vt[i].e_busy);
      end

      // Starvation: D reads and an I read pending forever, memory answers at once.
      do_reset();
      drive(1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 128'h0, 1'b1, 128'h0);
      cyc = 0;
      while (got_addr.size() < 10 && cyc < 200) begin
         @(negedge clk);
         #1;
         if (busy) got_addr.push_back(p_addr);
         cyc++;
      end
      chk("starve.grant_count", 128'(got_addr.size()), 128'd10);
      for (int g = 0; g < got_addr.size(); g++) begin
         exp_addr = ((g % (LIMIT + 1)) == LIMIT) ? 16'h1111 : 16'h2222;
         chk($sformatf("starve.grant%0d", g), 128'(got_addr[g]), 128'(exp_addr));
      end

      // Asynchronous reset in the middle of a D write-back.
      do_reset();
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h3333, w2, 1'b0, 128'h0);
      cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!busy && cyc < 10);
      chk("rst.busy_reached", 128'(busy), 128'd1);
      chk("rst.write_before", 128'(p_wr), 128'd1);
      #2;
      resp = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_outs("rst.during", 1'b0, 1'b0, 16'h0000, 128'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 128'h0, 1'b0, 128'h0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_outs("rst.after", 1'b0, 1'b0, 16'h0000, 128'h0, 1'b0, 1'b0, 1'b0);

      // Random traffic against the reference model.
      do_reset();
      m_owner = 0; m_cool = 1'b0; m_streak = 0;
      m_rd = 1'b0; m_wr = 1'b0; m_addr = 16'h0; m_wd = 128'h0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         ir   = ($urandom_range(0, 2) != 0);
         ia   = 16'($urandom);
         dr   = ($urandom_range(0, 2) == 0);
         dw   = ($urandom_range(0, 2) == 0);
         da   = 16'($urandom);
         wd   = {$urandom, $urandom, $urandom, $urandom};
         resp = ($urandom_range(0, 3) == 0);
         rdat = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk_outs("rand", m_rd, m_wr, m_addr, m_wd,
                  (m_owner == 1) && resp, (m_owner == 2) && resp, m_owner != 0);
         @(posedge clk);
         d_req = dr | dw;
         if (m_owner != 0) begin
            if (resp) begin
               m_owner = 0; m_cool = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
            end
         end else if (m_cool) begin
            m_cool = 1'b0;
         end else if (ir && (!d_req || m_streak == LIMIT)) begin
            m_owner = 1; m_rd = 1'b1; m_wr = 1'b0; m_addr = ia; m_streak = 0;
         end else if (d_req) begin
            m_owner = 2; m_wr = dw; m_rd = !dw; m_addr = da;
            if (dw) m_wd = wd;
            if (ir) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
